v2f_seq_divmod: RTL and testbench
=================================

Name: v2f_seq_divmod

Overview:
Iterative multi-cycle divider/modulo unit for operands wider than the 32-bit native combinator datapath, up to 64 bits. It computes quotient and remainder with a valid/ready handshake, one restoring step per cycle. It generalises the single-cycle v2f_div/v2f_mod primitives in width, signedness mode, and flow control. Designs instantiate it wherever division is wider than 32 bits and multi-cycle latency is acceptable.

Parameters:
WIDTH, 64, operand/result width in bits; legal range 2..64.
SIGNED, 0, 1 = two's-complement truncating division; 0 = unsigned.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  dividend.
b  input  WIDTH  divisor.
out_valid  output  1  results valid.
out_ready  input  1  consumer accepts results.
quot  output  WIDTH  quotient.
rem  output  WIDTH  remainder.
div_zero  output  1  flags that b was 0 for this result.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-low; it is sampled on clk rising edge.
- Reset values: state=IDLE; quot=0, rem=0, div_zero=0, out_valid=0.
- in_ready: decoded as (state==IDLE) && rst_n, so it reads 0 while rst_n is low.
- Reset mid-operation: aborts immediately. No result is emitted, and the next accept is possible on the first edge after rst_n goes high.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T0, latch |a|, |b|, sign(a), sign(b); count=0. Go to CALC, or to DONE if b==0.
  - CALC: one restoring step per cycle: shift {R,Q} left 1; if R>=|b| then R-=|b| and Q[0]=1. count increments and wraps at WIDTH. After step WIDTH-1 go to FIX.
  - FIX: apply signs and register quot/rem. Go to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready go to IDLE.
- Latency: out_valid first high in cycle T0+WIDTH+2 (66 cycles for WIDTH=64). Divide-by-zero latency is T0+1.
- Throughput: one operation in flight. No accept is possible in the same cycle as a result handshake; the next accept is at the earliest T_handshake+1.
- Arithmetic: magnitudes are WIDTH bits; the partial remainder is WIDTH+1 bits to hold the comparison carry.
- Signed mode:
  - Magnitude of the most negative value (MIN) is 2^(WIDTH-1), held in the unsigned magnitude register.
  - quot is negated iff sign(a)!=sign(b).
  - rem takes the sign of a (truncating division, matching Verilog / and %).
- Overflow: signed MIN / -1 gives quot=MIN (wraps), rem=0, div_zero=0.
- Divide by zero: quot=all ones, rem=a (unmodified), div_zero=1. Same in both modes.
- Output stability: quot, rem and div_zero are held stable while out_valid && !out_ready. in_valid is ignored outside IDLE. Inputs a and b need only be valid in the accept cycle.
- X-safety: no output depends on a or b outside an accept.

Decomposition:
- Shared package v2f_pkg holds:
  - state enum {IDLE, CALC, FIX, DONE};
  - localparam V2F_NATIVE_WIDTH=32;
  - a helper function for clog2 of the count width.
- Sub-module v2f_divmod_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder and next quotient.
  - Verified standalone, then instantiated once in the CALC datapath.

Test Plan:
- Unsigned, WIDTH=64: a=1000000000000, b=7 -> quot=142857142857, rem=1, div_zero=0; out_valid exactly 66 cycles after accept.
- Signed, WIDTH=64: a=-7, b=2 -> quot=-3, rem=-1; then a=7, b=-2 -> quot=-3, rem=1; then a=MIN, b=-1 -> quot=MIN, rem=0.
- Divide by zero: a=0x1234, b=0 -> one cycle after accept, out_valid=1, quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234, div_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable and in_ready=0 throughout. Raise out_ready: handshake, in_ready=1 next cycle, and a back-to-back new operation completes correctly.
- Reset mid-op: drop rst_n for 1 cycle at CALC count=20. All outputs are 0, in_ready=0 during reset and 1 after; no stale out_valid. The next operation 100/9 gives quot=11, rem=1.
- Random sweep: 2000 random operand pairs, WIDTH=64 and WIDTH=33, both SIGNED settings, with random in_valid/out_ready stalls. Compare against a reference model using / and %, including b=0 and MIN cases.

Source files
------------

// File: rtl/v2f_pkg.sv
// rtl/v2f_pkg.sv - shared types and helpers for the v2f sequential arithmetic blocks
package v2f_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } v2f_state_t;

    localparam int V2F_NATIVE_WIDTH = 32;

    // Step counter width; never narrower than one bit.
    function automatic int v2f_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/v2f_divmod_step.sv
// rtl/v2f_divmod_step.sv - one combinational restoring divide iteration
module v2f_divmod_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_cur,
    input  logic [WIDTH-1:0] quot_cur,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;
    logic           fits;

    assign rem_shift = {rem_cur, quot_cur[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor};

    // With the top bit clear both operands are below 2^WIDTH, so diff's MSB is an exact borrow.
    assign fits      = rem_shift[WIDTH] | ~diff[WIDTH];

    assign rem_next  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_next = {quot_cur[WIDTH-2:0], fits};

endmodule

// File: rtl/v2f_seq_divmod.sv
// rtl/v2f_seq_divmod.sv - iterative wide divider/modulo with valid/ready handshake
module v2f_seq_divmod
    import v2f_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int            CW   = v2f_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    v2f_state_t       state;
    v2f_state_t       state_next;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quot_acc;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;
    logic [CW-1:0]    count;
    logic             sign_a;
    logic             sign_b;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             b_zero;

    // MIN negates to itself, which is exactly its unsigned magnitude.
    assign in_sign_a = SIGNED & a[WIDTH-1];
    assign in_sign_b = SIGNED & b[WIDTH-1];
    assign a_mag     = in_sign_a ? -a : a;
    assign b_mag     = in_sign_b ? -b : b;
    assign accept    = in_valid & in_ready;
    assign b_zero    = (b == '0);

    v2f_divmod_step #(.WIDTH(WIDTH)) u_step (
        .rem_cur   (rem_acc),
        .quot_cur  (quot_acc),
        .divisor   (div_mag),
        .rem_next  (rem_step),
        .quot_next (quot_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = b_zero ? DONE : CALC;
            CALC:    if (count == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && rst_n;
        out_valid = (state == DONE) && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_acc  <= '0;
            quot_acc <= '0;
            div_mag  <= '0;
            count    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_acc  <= '0;
                        quot_acc <= a_mag;
                        div_mag  <= b_mag;
                        count    <= '0;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        // Divide by zero skips the datapath and returns the raw dividend.
                        if (b_zero) begin
                            quot     <= '1;
                            rem      <= a;
                            div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_acc  <= rem_step;
                    quot_acc <= quot_step;
                    count    <= (count == LAST) ? '0 : count + 1'b1;
                end
                FIX: begin
                    quot     <= (sign_a ^ sign_b) ? -quot_acc : quot_acc;
                    rem      <= sign_a ? -rem_acc : rem_acc;
                    div_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v2f_seq_divmod.sv
// tb/tb_v2f_seq_divmod.sv - scoreboard bench for v2f_seq_divmod across widths and sign modes
`timescale 1ns/1ps
module tb_v2f_seq_divmod;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [4];
    logic        ordy [4];
    logic [63:0] a_d  [4];
    logic [63:0] b_d  [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        dz   [4];
    logic [63:0] q_d  [4];
    logic [63:0] r_d  [4];
    exp_t        sb   [4][$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Instances 0/1: 64-bit unsigned/signed, 2/3: 33-bit unsigned/signed.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g < 2) ? 64 : 33;
        logic [W-1:0] qw;
        logic [W-1:0] rw;
        v2f_seq_divmod #(.WIDTH(W), .SIGNED(g % 2 == 1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (a_d[g][W-1:0]),
            .b         (b_d[g][W-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .quot      (qw),
            .rem       (rw),
            .div_zero  (dz[g])
        );
        assign q_d[g] = 64'(qw);
        assign r_d[g] = 64'(rw);
    end

    function automatic int wid(input int d);
        return (d < 2) ? 64 : 33;
    endfunction

    function automatic logic [63:0] wmask(input int d);
        return (wid(d) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wid(d)) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int d, input logic [63:0] a_in, input logic [63:0] b_in);
        int          w     = wid(d);
        logic [63:0] mask  = wmask(d);
        logic [63:0] min_v = 64'd1 << (w - 1);
        logic [63:0] a     = a_in & mask;
        logic [63:0] b     = b_in & mask;
        logic [63:0] tq;
        logic [63:0] tr;
        longint      sa;
        longint      sbv;
        exp_t        e;
        e.dz = 1'b0;
        if (b == 64'd0) begin
            e.q  = mask;
            e.r  = a;
            e.dz = 1'b1;
        end else if (d % 2 == 1) begin
            if (a == min_v && b == mask) begin
                e.q = min_v;
                e.r = 64'd0;
            end else begin
                sa  = longint'(a[w-1] ? (a | ~mask) : a);
                sbv = longint'(b[w-1] ? (b | ~mask) : b);
                tq  = sa / sbv;
                tr  = sa % sbv;
                e.q = tq & mask;
                e.r = tr & mask;
            end
        end else begin
            e.q = (a / b) & mask;
            e.r = (a % b) & mask;
        end
        return e;
    endfunction

    task automatic do_op(input int d, input logic [63:0] a, input logic [63:0] b,
                         input int iv_wait, input int stall, input int exp_lat,
                         input bit fuzz, input bit watch);
        exp_t e;
        int   n;
        int   lat;
        repeat (iv_wait) @(negedge clk);
        a_d[d] = a;
        b_d[d] = b;
        iv[d]  = 1'b1;
        n = 0;
        while (!ir[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 300), 64'd0);
        sb[d].push_back(model(d, a, b));
        @(posedge clk);
        #1;
        iv[d]  = 1'b0;
        a_d[d] = {$urandom, $urandom};
        b_d[d] = {$urandom, $urandom};
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (fuzz && !ov[d]) begin
                iv[d]  = 1'($urandom_range(0, 1));
                a_d[d] = {$urandom, $urandom};
                b_d[d] = {$urandom, $urandom};
            end
        end while (!ov[d] && lat < 300);
        iv[d] = 1'b0;
        check("done_timeout", 64'(lat >= 300), 64'd0);
        if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
        e = sb[d].pop_front();
        repeat (stall) begin
            if (watch) begin
                check("hold_quot", q_d[d], e.q);
                check("hold_rem", r_d[d], e.r);
                check("hold_in_ready", 64'(ir[d]), 64'd0);
                check("hold_valid", 64'(ov[d]), 64'd1);
            end
            @(negedge clk);
        end
        check("quot", q_d[d], e.q);
        check("rem", r_d[d], e.r);
        check("div_zero", 64'(dz[d]), 64'(e.dz));
        check("out_valid", 64'(ov[d]), 64'd1);
        ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        if (watch) begin
            @(negedge clk);
            check("in_ready_after", 64'(ir[d]), 64'd1);
        end
    endtask

    task automatic sweep(input int d);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] mask;
        mask = wmask(d);
        for (int i = 0; i < 500; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = 64'd0;
                1: begin
                    a = 64'd1 << (wid(d) - 1);
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: a = 64'd1 << (wid(d) - 1);
                3, 4: b = 64'($urandom_range(1, 1000));
                5: b = ~64'($urandom_range(0, 1000));
                default: begin
                end
            endcase
            do_op(d, a, b, $urandom_range(0, 2), $urandom_range(0, 3),
                  ((b & mask) == 64'd0) ? 1 : wid(d) + 2, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
            a_d[d]  = 64'd0;
            b_d[d]  = 64'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(ov[0]), 64'd0);
        check("rst_quot", q_d[0], 64'd0);
        check("rst_rem", r_d[0], 64'd0);
        check("rst_div_zero", 64'(dz[0]), 64'd0);
        check("rst_in_ready", 64'(ir[0]), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 64'(ir[0]), 64'd1);

        do_op(0, 64'd1000000000000, 64'd7, 1, 0, 66, 1'b0, 1'b0);
        do_op(1, -64'sd7, 64'd2, 1, 0, 66, 1'b0, 1'b0);
        do_op(1, 64'd7, -64'sd2, 1, 0, 66, 1'b0, 1'b0);
        do_op(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 66, 1'b0, 1'b0);
        do_op(0, 64'h1234, 64'd0, 1, 0, 1, 1'b0, 1'b0);
        do_op(1, 64'h1234, 64'd0, 1, 0, 1, 1'b0, 1'b0);

        do_op(0, 64'hDEAD_BEEF_0123_4567, 64'h1_0001, 1, 10, 66, 1'b0, 1'b1);
        do_op(0, 64'd999, 64'd10, 0, 0, 66, 1'b0, 1'b0);

        // Abort an operation with the step counter at 20.
        @(negedge clk);
        check("midop_ready", 64'(ir[0]), 64'd1);
        a_d[0] = 64'd5000;
        b_d[0] = 64'd3;
        iv[0]  = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(ov[0]), 64'd0);
        check("midrst_quot", q_d[0], 64'd0);
        check("midrst_rem", r_d[0], 64'd0);
        check("midrst_div_zero", 64'(dz[0]), 64'd0);
        check("midrst_in_ready", 64'(ir[0]), 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", 64'(ir[0]), 64'd1);
        do_op(0, 64'd100, 64'd9, 0, 0, 66, 1'b0, 1'b0);
        do_op(2, 64'h1_FFFF_FFFF, 64'd3, 1, 0, 35, 1'b0, 1'b0);
        do_op(3, 64'h1_0000_0000, 64'h1_FFFF_FFFF, 1, 0, 35, 1'b0, 1'b0);

        fork
            sweep(0);
            sweep(1);
            sweep(2);
            sweep(3);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
